imem_prog_fetch: RTL and testbench

- Parametrised, clocked instruction memory for the pipelined RISC-V core.
- Has two ports:
  - Fetch port (IF stage): byte-addressed, 1-cycle registered read, with stall and flush control.
  - Program-load port: valid/ready stream with an auto-incrementing write pointer, used to fill the array at run time.
- Flags misaligned and out-of-range fetches.
- Returns a canonical NOP whenever no valid instruction is available.

---
 rtl/rv_imem_pkg.sv | 22 ++
 rtl/imem_loader_fsm.sv | 90 +++++++++
 rtl/imem_prog_fetch.sv | 93 +++++++++
 tb/tb_imem_prog_fetch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_imem_pkg.sv
// rtl/rv_imem_pkg.sv - shared types and helpers for the instruction memory
// Contents:
//   NOP_INST_DEFAULT  canonical NOP (addi x0,x0,0)
//   loader_state_t    loader FSM states
//   word_index()      byte address -> word index within a DEPTH-word array
package rv_imem_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

  // Drops the byte offset and wraps into the array; range checking is done
  // separately by the caller.
  function automatic int unsigned word_index(input logic [31:0] byte_addr,
                                             input int unsigned depth);
    return int'((byte_addr >> 2) & (depth - 1));
  endfunction

endpackage

// File: rtl/imem_loader_fsm.sv
// rtl/imem_loader_fsm.sv - program-load stream controller for the instruction memory
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   prog_start        pulse: begin a load at word 0 (ignored while loading)
//   prog_valid        stream word valid
//   prog_last         stream word is the final one
//   prog_ready        word accepted this cycle when valid
//   prog_busy         load in progress
//   prog_count        words written by the current or most recent load
//   wr_en, wr_idx     array write enable and word index
module imem_loader_fsm
  import rv_imem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_start,
  input  logic                       prog_valid,
  input  logic                       prog_last,
  output logic                       prog_ready,
  output logic                       prog_busy,
  output logic [$clog2(DEPTH):0]     prog_count,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_idx
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  loader_state_t     state;
  loader_state_t     state_next;
  logic [IW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic              start_load;
  logic              hs;
  logic              at_end;

  assign start_load = (state == IDLE) && prog_start;
  assign hs         = (state == LOAD) && prog_valid;
  assign at_end     = (wptr == IW'(DEPTH - 1));

  // State register plus the pointer/count that advance with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (start_load) begin
        wptr  <= '0;
        count <= '0;
      end else if (hs) begin
        // wptr wraps to 0 after the final slot, but the FSM is back in
        // IDLE by then so the wrapped value is never used for a write.
        wptr  <= wptr + IW'(1);
        count <= count + CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (prog_start) state_next = LOAD;
      LOAD: if (hs && (prog_last || at_end)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prog_ready = 1'b0;
    prog_busy  = 1'b0;
    wr_en      = 1'b0;
    case (state)
      LOAD: begin
        prog_ready = 1'b1;
        prog_busy  = 1'b1;
        // A word arriving on the reset edge is dropped with the load.
        wr_en      = prog_valid && !rst;
      end
      default: ;
    endcase
  end

  assign prog_count = count;
  assign wr_idx     = wptr;

endmodule

// File: rtl/imem_prog_fetch.sv
// rtl/imem_prog_fetch.sv - instruction memory with IF fetch port and stream program loader
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   prog_start/valid/data/last        program-load stream in
//   prog_ready/busy/count             loader status out
//   fetch_req/stall/flush/addr        IF-stage fetch request (byte address)
//   fetch_inst/valid/err              registered fetch response, 1-cycle latency
module imem_prog_fetch
  import rv_imem_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              AW       = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_start,
  input  logic                    prog_valid,
  input  logic [XLEN-1:0]         prog_data,
  input  logic                    prog_last,
  output logic                    prog_ready,
  output logic                    prog_busy,
  output logic [$clog2(DEPTH):0]  prog_count,
  input  logic                    fetch_req,
  input  logic                    fetch_stall,
  input  logic                    fetch_flush,
  input  logic [AW-1:0]           fetch_addr,
  output logic [XLEN-1:0]         fetch_inst,
  output logic                    fetch_valid,
  output logic                    fetch_err
);

  localparam int IW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_data;
  logic            valid_q;
  logic            err_q;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            fetch_bad;
  logic            rd_en;

  imem_loader_fsm #(
    .DEPTH (DEPTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .prog_busy  (prog_busy),
    .prog_count (prog_count),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx)
  );

  // Out of range means any address bit above the array's byte span is set.
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IW + 2)) != '0);
  assign rd_idx    = IW'(word_index(32'(fetch_addr), DEPTH));
  assign rd_en     = !prog_busy && !fetch_flush && !fetch_stall && fetch_req && !fetch_bad;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= prog_data;
  end

  // Plain enabled read register so the array maps onto a synchronous RAM;
  // holding it during stall keeps the stalled instruction on the output.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (prog_busy || fetch_flush) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (!fetch_stall) begin
      valid_q <= fetch_req && !fetch_bad;
      err_q   <= fetch_req && fetch_bad;
    end
  end

  assign fetch_inst  = valid_q ? rd_data : NOP_INST;
  assign fetch_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_prog_fetch.sv
// tb/tb_imem_prog_fetch.sv - self-checking bench for imem_prog_fetch
module tb_imem_prog_fetch;

  localparam int DEPTH = 16;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_start, prog_valid, prog_last;
  logic [31:0]   prog_data;
  logic          prog_ready, prog_busy;
  logic [CW-1:0] prog_count;
  logic          fetch_req, fetch_stall, fetch_flush;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_inst;
  logic          fetch_valid, fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  imem_prog_fetch #(
    .XLEN (32), .DEPTH (DEPTH), .AW (32), .NOP_INST (NOP)
  ) dut (
    .clk (clk), .rst (rst),
    .prog_start (prog_start), .prog_valid (prog_valid), .prog_data (prog_data),
    .prog_last (prog_last), .prog_ready (prog_ready), .prog_busy (prog_busy),
    .prog_count (prog_count),
    .fetch_req (fetch_req), .fetch_stall (fetch_stall), .fetch_flush (fetch_flush),
    .fetch_addr (fetch_addr), .fetch_inst (fetch_inst), .fetch_valid (fetch_valid),
    .fetch_err (fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference fetch response from the rules: aligned and below DEPTH*4 reads the
  // model array; anything else is an error returning NOP.
  function automatic void exp_fetch(input logic [31:0] a, input logic req,
                                    output logic [31:0] i, output logic v, output logic e);
    if (!req) begin
      i = NOP; v = 1'b0; e = 1'b0;
    end else if ((a % 4) != 0 || a >= DEPTH * 4) begin
      i = NOP; v = 1'b0; e = 1'b1;
    end else begin
      i = ref_mem[a / 4]; v = 1'b1; e = 1'b0;
    end
  endfunction

  task automatic start_load();
    prog_start = 1'b1;
    step();
    prog_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    step(); step();
    n_cmp++; if (fetch_inst !== NOP) begin n_bad++; $display("FAIL reset_inst got %h want %h", fetch_inst, NOP); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", fetch_err); end
    n_cmp++; if (prog_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", prog_busy); end
    n_cmp++; if (prog_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", prog_ready); end
    n_cmp++; if (prog_count !== CW'(0)) begin n_bad++; $display("FAIL reset_count got %0d want 0", prog_count); end
    rst = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_small_load();
    logic [31:0] w [3];
    logic [31:0] ei; logic ev, ee;
    w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113; w[2] = 32'h0020_81B3;
    start_load();
    n_cmp++; if (prog_busy !== 1'b1) begin n_bad++; $display("FAIL load_busy got %b want 1", prog_busy); end
    n_cmp++; if (prog_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready got %b want 1", prog_ready); end
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1'b1; prog_data = w[i]; prog_last = (i == 2);
      step();
      ref_mem[i] = w[i];
      n_cmp++; if (prog_count !== CW'(i + 1)) begin n_bad++; $display("FAIL load_count%0d got %0d want %0d", i, prog_count, i + 1); end
    end
    prog_valid = 1'b0; prog_last = 1'b0;
    n_cmp++; if (prog_busy !== 1'b0) begin n_bad++; $display("FAIL load_busy_drop got %b want 0", prog_busy); end
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'(i * 4);
      step();
      exp_fetch(fetch_addr, 1'b1, ei, ev, ee);
      n_cmp++; if (fetch_inst !== ei || fetch_valid !== ev || fetch_err !== ee)
        begin n_bad++; $display("FAIL small_fetch%0d got %h/%b/%b want %h/%b/%b", i, fetch_inst, fetch_valid, fetch_err, ei, ev, ee); end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [2];
    addrs[0] = 32'h6; addrs[1] = 32'(DEPTH * 4);
    for (int k = 0; k < 2; k++) begin
      fetch_req = 1'b1; fetch_addr = addrs[k];
      step();
      n_cmp++; if (fetch_inst !== NOP || fetch_valid !== 1'b0 || fetch_err !== 1'b1)
        begin n_bad++; $display("FAIL err_addr_%h got %h/%b/%b want %h/0/1", addrs[k], fetch_inst, fetch_valid, fetch_err, NOP); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] w, first_w;
    int m_count;
    bit m_busy;
    first_w = 32'h0;
    start_load();
    m_count = 0; m_busy = 1'b1;
    for (int j = 0; j < DEPTH + 2; j++) begin
      w = $urandom;
      if (j == 0) first_w = w;
      prog_valid = 1'b1; prog_data = w; prog_last = 1'b0;
      step();
      if (m_busy) begin
        ref_mem[m_count] = w;
        m_count++;
        if (m_count == DEPTH) m_busy = 1'b0;
      end
      n_cmp++; if (prog_ready !== m_busy) begin n_bad++; $display("FAIL ovf_ready%0d got %b want %b", j, prog_ready, m_busy); end
      n_cmp++; if (prog_count !== CW'(m_count)) begin n_bad++; $display("FAIL ovf_count%0d got %0d want %0d", j, prog_count, m_count); end
    end
    prog_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    n_cmp++; if (fetch_inst !== first_w || fetch_valid !== 1'b1)
      begin n_bad++; $display("FAIL ovf_word0 got %h/%b want %h/1", fetch_inst, fetch_valid, first_w); end
    fetch_req = 1'b0;
  endtask

  task automatic test_random_fetch();
    logic [31:0] ei; logic ev, ee;
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        1: fetch_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        2: fetch_addr = 32'(DEPTH * 4 + $urandom_range(0, 4000));
        default: fetch_addr = $urandom;
      endcase
      fetch_req = ($urandom_range(0, 4) != 0);
      step();
      exp_fetch(fetch_addr, fetch_req, ei, ev, ee);
      n_cmp++; if (fetch_inst !== ei || fetch_valid !== ev || fetch_err !== ee)
        begin n_bad++; $display("FAIL rnd_fetch a=%h req=%b got %h/%b/%b want %h/%b/%b", fetch_addr, fetch_req, fetch_inst, fetch_valid, fetch_err, ei, ev, ee); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_stall_flush();
    logic [31:0] ei; logic ev, ee;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    exp_fetch(32'h4, 1'b1, ei, ev, ee);
    fetch_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fetch_addr = $urandom;
      step();
      n_cmp++; if (fetch_inst !== ei || fetch_valid !== ev || fetch_err !== ee)
        begin n_bad++; $display("FAIL stall_hold%0d got %h/%b/%b want %h/%b/%b", c, fetch_inst, fetch_valid, fetch_err, ei, ev, ee); end
    end
    fetch_flush = 1'b1; fetch_addr = 32'h8;
    step();
    n_cmp++; if (fetch_inst !== NOP || fetch_valid !== 1'b0 || fetch_err !== 1'b0)
      begin n_bad++; $display("FAIL flush_over_stall got %h/%b/%b want %h/0/0", fetch_inst, fetch_valid, fetch_err, NOP); end
    fetch_flush = 1'b0; fetch_stall = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] ei; logic ev, ee;
    start_load();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1'b1; prog_data = $urandom; prog_last = 1'b0;
      step();
      ref_mem[i] = prog_data;
    end
    prog_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (prog_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", prog_busy); end
    n_cmp++; if (prog_count !== CW'(0)) begin n_bad++; $display("FAIL rst_mid_count got %0d want 0", prog_count); end
    for (int i = 0; i < 2; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'(i * 4);
      step();
      exp_fetch(fetch_addr, 1'b1, ei, ev, ee);
      n_cmp++; if (fetch_inst !== ei || fetch_valid !== ev)
        begin n_bad++; $display("FAIL rst_mid_keep%0d got %h/%b want %h/%b", i, fetch_inst, fetch_valid, ei, ev); end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_fetch_during_load();
    logic [31:0] w;
    start_load();
    fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++; if (fetch_valid !== 1'b0 || fetch_inst !== NOP || fetch_err !== 1'b0)
        begin n_bad++; $display("FAIL busy_block%0d got %h/%b/%b want %h/0/0", c, fetch_inst, fetch_valid, fetch_err, NOP); end
    end
    w = $urandom;
    prog_valid = 1'b1; prog_data = w; prog_last = 1'b1;
    step();
    ref_mem[0] = w;
    prog_valid = 1'b0; prog_last = 1'b0;
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL busy_block_last got %b want 0", fetch_valid); end
    step();
    n_cmp++; if (fetch_inst !== w || fetch_valid !== 1'b1)
      begin n_bad++; $display("FAIL after_load got %h/%b want %h/1", fetch_inst, fetch_valid, w); end
    fetch_req = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
    fetch_req = 1'b0; fetch_stall = 1'b0; fetch_flush = 1'b0; fetch_addr = '0;
    test_reset();
    test_small_load();
    test_errors();
    test_overflow();
    test_random_fetch();
    test_stall_flush();
    test_reset_mid_load();
    test_fetch_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
